// File: rtl/perceptron_trainer_pkg.sv
// Shared Q16.16 constants and FSM state encoding for the perceptron trainer.
package perceptron_trainer_pkg;

  localparam int unsigned WEIGHT_W = 32;

  // Signed 32-bit saturation bounds for weight arithmetic.
  localparam logic [WEIGHT_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [WEIGHT_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StEval,
    StUpdate,
    StResult
  } state_e;

endpackage

// File: rtl/sat_addsub.sv
// 32-bit signed saturating add/subtract, purely combinational.
module sat_addsub
  import perceptron_trainer_pkg::*;
(
  input  logic [WEIGHT_W-1:0] a_i,
  input  logic [WEIGHT_W-1:0] b_i,
  input  logic                sub_i,
  output logic [WEIGHT_W-1:0] y_o
);

  logic [WEIGHT_W:0] a_ext;
  logic [WEIGHT_W:0] b_ext;
  logic [WEIGHT_W:0] full;

  // One guard bit exposes overflow; clamp instead of wrapping.
  always_comb begin
    a_ext = {a_i[WEIGHT_W-1], a_i};
    b_ext = {b_i[WEIGHT_W-1], b_i};
    full  = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
    if (full[WEIGHT_W] != full[WEIGHT_W-1]) begin
      y_o = full[WEIGHT_W] ? SAT_MIN : SAT_MAX;
    end else begin
      y_o = full[WEIGHT_W-1:0];
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training controller: latches a binary sample, waits for the external
// weighted_sum to settle, classifies, applies the perceptron rule on error and
// reports the result.
module perceptron_trainer
  import perceptron_trainer_pkg::*;
#(
  parameter int unsigned        N           = 8,
  parameter int unsigned        LATENCY     = 2,
  parameter logic [31:0]        ETA         = 32'h0000_1000,
  parameter logic signed [31:0] THRESHOLD   = 32'sh0000_0000,
  parameter logic [31:0]        INIT_WEIGHT = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [N-1:0]          x_in,
  input  logic                  target,
  input  logic [31:0]           sum,
  output logic [N-1:0]          x,
  output logic [WEIGHT_W*N-1:0] w,
  input  logic                  w_load,
  input  logic [WEIGHT_W*N-1:0] w_load_data,
  input  logic                  clr_count,
  output logic                  result_valid,
  output logic                  y,
  output logic                  err,
  output logic [15:0]           err_count
);

  localparam int unsigned CntW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(LATENCY);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [N-1:0]          x_q, x_d;
  logic                  tgt_q, tgt_d;
  logic [WEIGHT_W*N-1:0] w_q, w_d;
  logic                  y_q, y_d;
  logic                  err_q, err_d;
  logic [15:0]           err_count_q, err_count_d;

  logic [WEIGHT_W*N-1:0] w_upd;
  logic                  y_new;
  logic                  err_new;

  // Candidate weights for an UPDATE cycle; only active inputs move.
  // An update only happens on error, so y == ~target and target alone picks the direction.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WEIGHT_W-1:0] lane_sum;

    sat_addsub u_sat (
      .a_i   (w_q[i*WEIGHT_W +: WEIGHT_W]),
      .b_i   (ETA),
      .sub_i (~tgt_q),
      .y_o   (lane_sum)
    );

    assign w_upd[i*WEIGHT_W +: WEIGHT_W] = x_q[i] ? lane_sum : w_q[i*WEIGHT_W +: WEIGHT_W];
  end

  assign y_new   = ($signed(sum) >= THRESHOLD);
  assign err_new = (y_new != tgt_q);

  // Next-state, datapath and counter logic for the training sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    tgt_d       = tgt_q;
    w_d         = w_q;
    y_d         = y_q;
    err_d       = err_q;
    err_count_d = err_count_q;

    unique case (state_q)
      StIdle: begin
        // A load coinciding with an accept lands first, so SETTLE sees loaded weights.
        if (w_load) begin
          w_d = w_load_data;
        end
        if (sample_valid) begin
          x_d     = x_in;
          tgt_d   = target;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StEval;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEval: begin
        y_d   = y_new;
        err_d = err_new;
        if (err_new && (err_count_q != 16'hFFFF)) begin
          err_count_d = err_count_q + 16'd1;
        end
        state_d = err_new ? StUpdate : StResult;
      end
      StUpdate: begin
        w_d     = w_upd;
        state_d = StResult;
      end
      StResult: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Clear takes priority over a coincident increment.
    if (clr_count) begin
      err_count_d = '0;
    end
  end

  // State registers with synchronous active-high reset; reset drops any in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      tgt_q       <= 1'b0;
      w_q         <= {N{INIT_WEIGHT}};
      y_q         <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      tgt_q       <= tgt_d;
      w_q         <= w_d;
      y_q         <= y_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign sample_ready = (state_q == StIdle);
  assign result_valid = (state_q == StResult);
  assign x            = x_q;
  assign w            = w_q;
  assign y            = y_q;
  assign err          = err_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: scoreboard of expected classifications
// plus a reference model of weights and the error counter.
module tb_perceptron_trainer;

  localparam int unsigned        N           = 8;
  localparam int unsigned        LATENCY     = 2;
  localparam logic [31:0]        ETA         = 32'h0000_1000;
  localparam logic signed [31:0] THRESHOLD   = 32'sh0000_0000;
  localparam logic [31:0]        INIT_WEIGHT = 32'h0000_0000;
  localparam longint             MaxL        = 64'sd2147483647;
  localparam longint             MinL        = -64'sd2147483648;

  logic            clk;
  logic            rst;
  logic            sample_valid;
  logic            sample_ready;
  logic [N-1:0]    x_in;
  logic            target;
  logic [31:0]     sum;
  logic [N-1:0]    x;
  logic [32*N-1:0] w;
  logic            w_load;
  logic [32*N-1:0] w_load_data;
  logic            clr_count;
  logic            result_valid;
  logic            y;
  logic            err;
  logic [15:0]     err_count;

  typedef struct {
    logic y;
    logic err;
    int   lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] w_m[N];
  logic [15:0] errm;
  int          checks;
  int          errors;

  perceptron_trainer #(
    .N           (N),
    .LATENCY     (LATENCY),
    .ETA         (ETA),
    .THRESHOLD   (THRESHOLD),
    .INIT_WEIGHT (INIT_WEIGHT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .x_in         (x_in),
    .target       (target),
    .sum          (sum),
    .x            (x),
    .w            (w),
    .w_load       (w_load),
    .w_load_data  (w_load_data),
    .clr_count    (clr_count),
    .result_valid (result_valid),
    .y            (y),
    .err          (err),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference saturating step of one weight by +/-ETA using wide integer arithmetic.
  function automatic logic [31:0] m_step(input logic [31:0] wv, input logic up);
    longint v;
    v = longint'($signed(wv));
    v = up ? v + longint'(ETA) : v - longint'(ETA);
    if (v > MaxL) v = MaxL;
    if (v < MinL) v = MinL;
    return v[31:0];
  endfunction

  task automatic check_weights(input string name);
    for (int i = 0; i < int'(N); i++) begin
      checks++;
      if (w[32*i +: 32] !== w_m[i]) begin
        errors++;
        $display("FAIL %s w[%0d]: got %h expected %h", name, i, w[32*i +: 32], w_m[i]);
      end
    end
  endtask

  task automatic load_weights(input logic [32*N-1:0] d);
    w_load      = 1'b1;
    w_load_data = d;
    @(posedge clk);
    #1;
    w_load = 1'b0;
    for (int i = 0; i < int'(N); i++) w_m[i] = d[32*i +: 32];
    check_weights("load");
  endtask

  // Drive one sample; load_edge/clr_edge pick the edge (relative to accept) for w_load/clr_count.
  task automatic run_sample(input string name, input logic [N-1:0] xv, input logic tv,
                            input logic [31:0] sv, input int load_edge,
                            input logic [32*N-1:0] load_data, input int clr_edge);
    exp_t e;
    exp_t got;
    int   lat;
    logic ym;
    logic em;
    ym = ($signed(sv) >= THRESHOLD);
    em = (ym != tv);
    e.y = ym;
    e.err = em;
    e.lat = int'(LATENCY) + 2 + (em ? 1 : 0);
    exp_q.push_back(e);
    if (load_edge == 0) begin
      for (int i = 0; i < int'(N); i++) w_m[i] = load_data[32*i +: 32];
    end

    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b expected 1", name, sample_ready);
    end
    x_in         = xv;
    target       = tv;
    sum          = sv;
    sample_valid = 1'b1;
    w_load       = (load_edge == 0);
    w_load_data  = load_data;
    clr_count    = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (x !== xv) begin
      errors++;
      $display("FAIL %s x_latch: got %h expected %h", name, x, xv);
    end

    lat = -1;
    for (int j = 1; j <= 20; j++) begin
      sample_valid = (j <= int'(LATENCY) + 1);
      x_in         = ~xv;
      target       = ~tv;
      w_load       = (j == load_edge);
      clr_count    = (j == clr_edge);
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) begin
        lat = j;
        break;
      end
    end
    sample_valid = 1'b0;
    w_load       = 1'b0;
    clr_count    = 1'b0;

    if (em) begin
      for (int i = 0; i < int'(N); i++) if (xv[i]) w_m[i] = m_step(w_m[i], tv);
      if (errm != 16'hFFFF) errm = errm + 16'd1;
    end
    if (clr_edge > 0) errm = '0;

    got = exp_q.pop_front();
    checks++;
    if (lat != got.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, got.lat);
    end
    checks++;
    if (y !== got.y) begin
      errors++;
      $display("FAIL %s y: got %b expected %b", name, y, got.y);
    end
    checks++;
    if (err !== got.err) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", name, err, got.err);
    end
    checks++;
    if (err_count !== errm) begin
      errors++;
      $display("FAIL %s err_count: got %0d expected %0d", name, err_count, errm);
    end
    checks++;
    if (x !== xv) begin
      errors++;
      $display("FAIL %s x_hold: got %h expected %h", name, x, xv);
    end
    check_weights(name);

    @(posedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0 || sample_ready !== 1'b1 || y !== got.y) begin
      errors++;
      $display("FAIL %s after_result: got rv=%b rdy=%b y=%b expected rv=0 rdy=1 y=%b",
               name, result_valid, sample_ready, y, got.y);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < int'(N); i++) w_m[i] = INIT_WEIGHT;
    errm = '0;
    check_weights("reset");
    checks++;
    if (sample_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got rdy=%b rv=%b expected rdy=1 rv=0", sample_ready, result_valid);
    end
    checks++;
    if (err_count !== 16'd0 || x !== '0 || y !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got cnt=%0d x=%h y=%b err=%b expected all 0",
               err_count, x, y, err);
    end
  endtask

  task automatic test_no_error();
    load_weights({N{32'h0000_8000}});
    run_sample("no_error", 8'h01, 1'b1, 32'h0000_8000, -1, '0, -1);
  endtask

  task automatic test_error_update();
    load_weights('0);
    run_sample("error_update", 8'h05, 1'b0, 32'h0000_0000, -1, '0, -1);
  endtask

  task automatic test_saturation();
    logic [32*N-1:0] d;
    d = '0;
    d[32*7 +: 32] = 32'h7FFF_F800;
    load_weights(d);
    run_sample("sat_pos", 8'h80, 1'b1, 32'hFFFF_0000, -1, '0, -1);
    d = '0;
    d[31:0] = 32'h8000_0800;
    load_weights(d);
    run_sample("sat_neg", 8'h01, 1'b0, 32'h0000_0000, -1, '0, -1);
  endtask

  task automatic test_load_and_clear();
    load_weights({N{32'h0000_2000}});
    run_sample("load_in_settle", 8'h0F, 1'b0, 32'h0000_4000, 1, {N{32'h1234_5678}},
               int'(LATENCY) + 2);
  endtask

  task automatic test_load_with_accept();
    run_sample("load_with_accept", 8'h03, 1'b0, 32'h0002_0000, 0, {N{32'h0001_0000}}, -1);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 6; s++) begin
      run_sample("back_to_back", N'($urandom), 1'($urandom_range(0, 1)), $urandom, -1, '0, -1);
    end
  endtask

  task automatic test_reset_in_update();
    bit pulsed;
    pulsed       = 1'b0;
    x_in         = 8'hFF;
    target       = 1'b0;
    sum          = 32'h0000_0000;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    for (int j = 1; j <= int'(LATENCY) + 3; j++) begin
      if (j == int'(LATENCY) + 3) rst = 1'b1;
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) pulsed = 1'b1;
    end
    for (int i = 0; i < int'(N); i++) w_m[i] = INIT_WEIGHT;
    errm = '0;
    check_weights("rst_in_update");
    checks++;
    if (sample_ready !== 1'b1 || err_count !== 16'd0 || y !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_update regs: got rdy=%b cnt=%0d y=%b err=%b expected 1 0 0 0",
               sample_ready, err_count, y, err);
    end
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) pulsed = 1'b1;
    end
    checks++;
    if (pulsed !== 1'b0 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_update pulse: got pulsed=%b rdy=%b expected 0 1", pulsed, sample_ready);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    errm         = '0;
    rst          = 1'b1;
    sample_valid = 1'b0;
    x_in         = '0;
    target       = 1'b0;
    sum          = '0;
    w_load       = 1'b0;
    w_load_data  = '0;
    clr_count    = 1'b0;
    #1;
    test_reset();
    test_no_error();
    test_error_update();
    test_saturation();
    test_load_and_clear();
    test_load_with_accept();
    test_back_to_back();
    test_reset_in_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
